sram_req_ctrl: RTL and testbench
================================

Name: sram_req_ctrl

Overview:
- Request-side controller that sits directly upstream of the 512x64 1R1W byte-masked behavioural SRAM (mem_0_ext) and drives all of its W0_*/R0_* ports.
- Converts a single valid/ready request channel (reads and masked writes) into SRAM port activity.
- Retires every request through an ordered, backpressured response FIFO.
- After reset, fills the whole array with a known value before accepting traffic.

Parameters:
- ADDR_W, 9, SRAM address width (depth = 2**ADDR_W).
- DATA_W, 64, SRAM word width.
- MASK_W, 8, write-mask width (DATA_W/MASK_W bits per lane).
- RESP_DEPTH, 4, response FIFO entries; also the outstanding-request credit limit (min 2).
- INIT_EN, 1, 1 = run the post-reset fill; 0 = go straight to RUN.
- INIT_VALUE, 0, word written to every address during the fill.

Ports:
- clock  in  1  sole clock; the SRAM W0_clk/R0_clk are tied to it externally.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when valid&&ready.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_data  in  DATA_W  write data.
- req_mask  in  MASK_W  per-lane write enable.
- resp_valid  out  1  response available.
- resp_ready  in  1  response consumed when valid&&ready.
- resp_write  out  1  1 = write acknowledge, 0 = read data.
- resp_data  out  DATA_W  read data; 0 for write acknowledges.
- init_done  out  1  high once the fill is finished.
- W0_en  out  1  SRAM write enable.
- W0_addr  out  ADDR_W  SRAM write address.
- W0_data  out  DATA_W  SRAM write data.
- W0_mask  out  MASK_W  SRAM write mask.
- R0_en  out  1  SRAM read enable.
- R0_addr  out  ADDR_W  SRAM read address.
- R0_data  in  DATA_W  SRAM read data; valid the cycle after R0_en.

Behaviour:
- Reset values (asynchronous assertion, all registered state):
  - Outputs: req_ready=0, resp_valid=0, init_done=0, W0_en=0, R0_en=0.
  - Internal: FIFO empty, p1_valid=0, credit count=0, state = INIT (INIT_EN=1) or RUN (INIT_EN=0).
  - Reset deassertion is assumed synchronised externally.
- FSM INIT:
  - 0..2**ADDR_W-1 counter drives W0_en=1, W0_addr=cnt, W0_data=INIT_VALUE, W0_mask=all ones, one address per cycle.
  - req_ready=0 throughout.
  - After address 2**ADDR_W-1 is written, go to RUN. The fill takes exactly 2**ADDR_W cycles.
- FSM RUN:
  - init_done=1 (registered, stays 1 until reset).
  - There is no return to INIT except via reset.
- Credits:
  - inflight = p1_valid + FIFO occupancy, from registered values.
  - req_ready = (state==RUN) && (inflight < RESP_DEPTH).
  - req_ready is independent of req_write and of the current-cycle resp_ready (no combinational path from resp_ready).
- Accepted write at cycle t:
  - W0_en=1, with W0_addr/W0_data/W0_mask driven combinationally from req_* in cycle t.
  - R0_en=0.
  - p1 loads {write=1} at the edge ending t.
- Accepted read at cycle t:
  - R0_en=1, R0_addr=req_addr in cycle t.
  - W0_en=0.
  - p1 loads {write=0}.
- Idle cycles: W0_en=0 and R0_en=0. W0_addr/W0_data/W0_mask/R0_addr are don't-care when their enable is low but must not be X; drive from req_*.
- p1 stage (cycle t+1):
  - If p1_valid, enqueue {write, write ? 0 : R0_data}.
  - R0_data is sampled only in this cycle; later SRAM reads do not disturb it.
- Ordering and latency:
  - Responses leave in strict acceptance order.
  - resp_valid rises at t+2 at the earliest (FIFO output is registered, no bypass).
- Throughput: with RESP_DEPTH>=3 and resp_ready held high, one request is accepted per cycle indefinitely.
- Read-after-write to the same address in consecutive cycles returns the new data. The SRAM captures the read address after the write edge, so no forwarding is needed.
- Simultaneous enqueue and dequeue while full cannot occur, because credits prevent it. Simultaneous enqueue and dequeue at any other occupancy leaves the count unchanged.
- FIFO pointers wrap modulo RESP_DEPTH.
- Reset mid-operation:
  - In-flight and queued responses are discarded.
  - The fill restarts from address 0.
  - Outputs return to their reset values immediately.

Decomposition:
- Shared package sram_ctrl_pkg holds:
  - state enum {ST_INIT, ST_RUN};
  - response struct resp_t {logic write; logic [DATA_W-1:0] data};
  - a localparam for the default RESP_DEPTH.
- One sub-module, sram_resp_fifo: parameterised synchronous FIFO with count output, async active-low reset, no bypass.

Test Plan:
- Reset, INIT_EN=1, ADDR_W=9 -> W0_en high for exactly 512 cycles with addresses 0..511 and mask 0xFF; init_done rises on the following cycle; req_ready=0 until then.
- After init, read addr 0x1A5 -> resp_write=0, resp_data=0x0 two cycles after acceptance.
- Write addr 0x010, data 0x1122334455667788, mask 0xFF; then write 0x010, data 0xAAAAAAAAAAAAAAAA, mask 0x0F; then read 0x010 on the next cycle -> two acks with resp_data=0, then read data 0x11223344AAAAAAAA.
- Backpressure: resp_ready=0 with 6 reads offered, RESP_DEPTH=4 -> exactly 4 accepted and req_ready=0; release resp_ready -> 4 responses in order, then the remaining 2 accepted.
- Streaming: 100 alternating writes/reads to random addresses with resp_ready=1 -> one request accepted per cycle and every read matches a scoreboard model.
- Assert reset_n low while 3 responses are queued -> resp_valid=0 immediately; after release the fill restarts at address 0 and no stale responses appear.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared types and defaults for the SRAM request controller and its
// response FIFO.
package sram_ctrl_pkg;

    // Default number of response FIFO entries (also the credit limit).
    localparam int RESP_DEPTH_DEF = 4;

    // Word width carried by a response entry; matches the SRAM word.
    localparam int RESP_DATA_W = 64;

    // Controller top-level state: fill the array, then serve requests.
    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // One retired request: write acknowledge (data 0) or read data.
    typedef struct packed {
        logic                   write;
        logic [RESP_DATA_W-1:0] data;
    } resp_t;

    // Counter width able to hold 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sram_req_ctrl_if.sv
// Request, response and SRAM-port bundle of the SRAM request controller.
// The slave view is the controller; the master view is its environment
// (requester, response consumer and the SRAM read-data return).
interface sram_req_ctrl_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 64,
    parameter int MASK_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic [MASK_W-1:0] req_mask;

    logic              resp_valid;
    logic              resp_ready;
    logic              resp_write;
    logic [DATA_W-1:0] resp_data;

    logic              W0_en;
    logic [ADDR_W-1:0] W0_addr;
    logic [DATA_W-1:0] W0_data;
    logic [MASK_W-1:0] W0_mask;
    logic              R0_en;
    logic [ADDR_W-1:0] R0_addr;
    logic [DATA_W-1:0] R0_data;

    modport master (
        output req_valid, req_write, req_addr, req_data, req_mask,
        output resp_ready, R0_data,
        input  req_ready, resp_valid, resp_write, resp_data,
        input  W0_en, W0_addr, W0_data, W0_mask, R0_en, R0_addr
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_data, req_mask,
        input  resp_ready, R0_data,
        output req_ready, resp_valid, resp_write, resp_data,
        output W0_en, W0_addr, W0_data, W0_mask, R0_en, R0_addr
    );
endinterface

// File: rtl/sram_resp_fifo.sv
// Ordered response FIFO. Output comes straight from storage registers
// (no enqueue-to-dequeue bypass), so an entry is visible the cycle after
// it is written.
module sram_resp_fifo
    import sram_ctrl_pkg::*;
#(
    parameter  int DEPTH = RESP_DEPTH_DEF,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = cnt_width(DEPTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enq_valid,
    input  resp_t            enq_data,
    input  logic             deq_ready,
    output logic             deq_valid,
    output resp_t            deq_data,
    output logic [CNT_W-1:0] count
);

    resp_t            mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             not_empty_r;
    logic             push_s;
    logic             pop_s;
    logic [CNT_W-1:0] count_next_s;

    // Pointers wrap modulo DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1'b1);
        end
    endfunction

    // Push/pop qualification and next occupancy.
    always_comb begin
        push_s       = enq_valid && (count_r != CNT_W'(DEPTH));
        pop_s        = not_empty_r && deq_ready;
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_W'(1'b1);
            2'b01:   count_next_s = count_r - CNT_W'(1'b1);
            default: count_next_s = count_r;
        endcase
    end

    // Storage, pointers, occupancy and the registered non-empty flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            not_empty_r <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {($bits(resp_t)){1'b0}};
            end
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= enq_data;
                wr_ptr_r        <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            count_r     <= count_next_s;
            not_empty_r <= (count_next_s != {CNT_W{1'b0}});
        end
    end

    assign deq_valid = not_empty_r;
    assign deq_data  = mem_r[rd_ptr_r];
    assign count     = count_r;

endmodule

// File: rtl/sram_req_ctrl.sv
// Request-side controller for a 1R1W byte-masked SRAM. Fills the array
// after reset, then turns valid/ready requests into SRAM port activity and
// retires each one, in order, through a credit-limited response FIFO.
module sram_req_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int              ADDR_W     = 9,
    parameter int              DATA_W     = RESP_DATA_W,
    parameter int              MASK_W     = 8,
    parameter int              RESP_DEPTH = RESP_DEPTH_DEF,
    parameter bit              INIT_EN    = 1'b1,
    parameter logic [DATA_W-1:0] INIT_VALUE = {DATA_W{1'b0}}
) (
    input  logic             clock,
    input  logic             reset_n,
    sram_req_ctrl_if.slave   bus,
    output logic             init_done
);

    localparam int CNT_W = cnt_width(RESP_DEPTH);
    localparam int INF_W = CNT_W + 1;

    state_e            state_r;
    state_e            state_next_s;
    logic              fill_en_r;
    logic [ADDR_W-1:0] fill_cnt_r;
    logic              init_done_r;
    logic              req_ready_r;
    logic              req_ready_next_s;
    logic              p1_valid_r;
    logic              p1_write_r;

    logic              accept_s;
    logic              deq_s;
    logic              fifo_valid_s;
    resp_t             fifo_out_s;
    resp_t             enq_entry_s;
    logic [CNT_W-1:0]  fifo_cnt_s;
    logic [CNT_W-1:0]  fifo_cnt_next_s;
    logic [INF_W-1:0]  inflight_next_s;

    logic              w0_en_s;
    logic [ADDR_W-1:0] w0_addr_s;
    logic [DATA_W-1:0] w0_data_s;
    logic [MASK_W-1:0] w0_mask_s;
    logic              r0_en_s;

    // SRAM port drive: fill writes while filling, otherwise the accepted request.
    always_comb begin
        accept_s = bus.req_valid && req_ready_r;
        if (fill_en_r) begin
            w0_en_s   = 1'b1;
            w0_addr_s = fill_cnt_r;
            w0_data_s = INIT_VALUE;
            w0_mask_s = {MASK_W{1'b1}};
        end else begin
            w0_en_s   = accept_s && bus.req_write;
            w0_addr_s = bus.req_addr;
            w0_data_s = bus.req_data;
            w0_mask_s = bus.req_mask;
        end
        r0_en_s = accept_s && !bus.req_write;
    end

    // Next state and next-cycle credit availability, so req_ready is a flop.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_INIT: begin
                if (fill_en_r && (fill_cnt_r == {ADDR_W{1'b1}})) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_INIT;
                end
            end
            ST_RUN:  state_next_s = ST_RUN;
            default: state_next_s = ST_INIT;
        endcase

        deq_s           = fifo_valid_s && bus.resp_ready;
        fifo_cnt_next_s = fifo_cnt_s;
        case ({p1_valid_r, deq_s})
            2'b10:   fifo_cnt_next_s = fifo_cnt_s + CNT_W'(1'b1);
            2'b01:   fifo_cnt_next_s = fifo_cnt_s - CNT_W'(1'b1);
            default: fifo_cnt_next_s = fifo_cnt_s;
        endcase

        // In-flight next cycle = new p1 occupant plus next FIFO occupancy.
        inflight_next_s  = {1'b0, fifo_cnt_next_s} + {{CNT_W{1'b0}}, accept_s};
        req_ready_next_s = (state_next_s == ST_RUN) && (inflight_next_s < INF_W'(RESP_DEPTH));
    end

    // FSM: fill sequencing (one idle cycle, then one address per cycle) and init_done.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= INIT_EN ? ST_INIT : ST_RUN;
            fill_en_r   <= 1'b0;
            fill_cnt_r  <= {ADDR_W{1'b0}};
            init_done_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            case (state_r)
                ST_INIT: begin
                    if (!fill_en_r) begin
                        fill_en_r <= 1'b1;
                    end else if (fill_cnt_r == {ADDR_W{1'b1}}) begin
                        fill_en_r <= 1'b0;
                    end else begin
                        fill_cnt_r <= fill_cnt_r + ADDR_W'(1'b1);
                    end
                end
                default: fill_en_r <= 1'b0;
            endcase
            init_done_r <= (state_next_s == ST_RUN);
        end
    end

    // Credit-gated ready and the p1 stage that waits for SRAM read data.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            req_ready_r <= 1'b0;
            p1_valid_r  <= 1'b0;
            p1_write_r  <= 1'b0;
        end else begin
            req_ready_r <= req_ready_next_s;
            p1_valid_r  <= accept_s;
            p1_write_r  <= bus.req_write;
        end
    end

    // Response entry built in the p1 cycle; R0_data is only valid here.
    always_comb begin
        enq_entry_s.write = p1_write_r;
        if (p1_write_r) begin
            enq_entry_s.data = {DATA_W{1'b0}};
        end else begin
            enq_entry_s.data = bus.R0_data;
        end
    end

    sram_resp_fifo #(
        .DEPTH (RESP_DEPTH)
    ) u_resp_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .enq_valid (p1_valid_r),
        .enq_data  (enq_entry_s),
        .deq_ready (bus.resp_ready),
        .deq_valid (fifo_valid_s),
        .deq_data  (fifo_out_s),
        .count     (fifo_cnt_s)
    );

    assign bus.req_ready  = req_ready_r;
    assign bus.resp_valid = fifo_valid_s;
    assign bus.resp_write = fifo_out_s.write;
    assign bus.resp_data  = fifo_out_s.data;
    assign bus.W0_en      = w0_en_s;
    assign bus.W0_addr    = w0_addr_s;
    assign bus.W0_data    = w0_data_s;
    assign bus.W0_mask    = w0_mask_s;
    assign bus.R0_en      = r0_en_s;
    assign bus.R0_addr    = bus.req_addr;
    assign init_done      = init_done_r;

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Testbench for sram_req_ctrl: behavioural SRAM, ordered scoreboard,
// table-driven vectors plus fill, latency, backpressure, streaming and
// mid-operation reset sequences.
module tb_sram_req_ctrl;

    logic clock = 1'b0;
    logic reset_n;
    logic init_done;

    sram_req_ctrl_if #(.ADDR_W(9), .DATA_W(64), .MASK_W(8)) bus ();

    sram_req_ctrl #(
        .ADDR_W     (9),
        .DATA_W     (64),
        .MASK_W     (8),
        .RESP_DEPTH (4),
        .INIT_EN    (1'b1),
        .INIT_VALUE (64'h0)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .bus       (bus),
        .init_done (init_done)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    int n_pop   = 0;

    typedef struct { bit w; logic [63:0] d; } exp_t;
    exp_t exp_q[$];

    typedef struct {
        bit          w;
        logic [8:0]  a;
        logic [63:0] d;
        logic [7:0]  m;
        logic [63:0] exp;
    } vec_t;

    logic [63:0] model [512];

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                          input logic [7:0] m);
        logic [63:0] r;
        r = old;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) r[8*i +: 8] = d[8*i +: 8];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural 512x64 1R1W masked SRAM; read sees a same-edge write.
    bit [63:0]   mem  [512];
    bit          seen [512];
    logic [63:0] r0_q = 64'h0;
    always @(posedge clock) begin
        if (bus.W0_en) begin
            mem[bus.W0_addr]  <= merge(mem[bus.W0_addr], bus.W0_data, bus.W0_mask);
            seen[bus.W0_addr] <= 1'b1;
        end
        if (bus.R0_en) begin
            if (bus.W0_en && bus.W0_addr == bus.R0_addr)
                r0_q <= merge(mem[bus.R0_addr], bus.W0_data, bus.W0_mask);
            else
                r0_q <= seen[bus.R0_addr] ? mem[bus.R0_addr] : 64'hDEAD_BEEF_DEAD_BEEF;
        end
    end
    assign bus.R0_data = r0_q;

    // Response monitor: pop the scoreboard on every response handshake.
    always @(negedge clock) begin
        if (reset_n && bus.resp_valid && bus.resp_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL resp_unexpected: got write=%0d data=%h expected no response",
                         bus.resp_write, bus.resp_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("resp_write", {63'h0, bus.resp_write}, {63'h0, e.w});
                check("resp_data", bus.resp_data, e.d);
                n_pop++;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input bit w, input logic [8:0] a, input logic [63:0] d,
                        input logic [7:0] m, input logic [63:0] exp, output int waits);
        exp_t e;
        waits = 0;
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_data  = d;
        bus.req_mask  = m;
        @(negedge clock);
        while (!bus.req_ready && waits < 200) begin
            waits++;
            @(negedge clock);
        end
        if (!bus.req_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: got req_ready=0 expected 1 within 200 cycles");
        end else begin
            e.w = w;
            e.d = w ? 64'h0 : exp;
            exp_q.push_back(e);
            if (w) model[a] = merge(model[a], d, m);
        end
        @(posedge clock); #1;
        bus.req_valid = 1'b0;
    endtask

    // Follows the fill from reset release until init_done rises.
    task automatic check_fill();
        int n = 0, bad = 0, last_w = -1, done_cyc = -1;
        bit done = 1'b0, rdy_bad = 1'b0, first_bad = 1'b0;
        for (int c = 1; c <= 700 && !done; c++) begin
            @(negedge clock);
            if (bus.W0_en) begin
                if (n == 0 && bus.W0_addr != 9'h000) first_bad = 1'b1;
                if (bus.W0_addr != n[8:0] || bus.W0_mask != 8'hFF || bus.W0_data != 64'h0) bad++;
                n++;
                last_w = c;
            end
            if (init_done) begin
                done     = 1'b1;
                done_cyc = c;
            end else if (bus.req_ready) begin
                rdy_bad = 1'b1;
            end
        end
        check("fill_done_seen", {63'h0, done}, 64'h1);
        check("fill_cycles", 64'(n), 64'd512);
        check("fill_addr_data_mask", 64'(bad), 64'd0);
        check("fill_starts_at_0", {63'h0, first_bad}, 64'h0);
        check("init_done_next_cycle", 64'(done_cyc), 64'(last_w + 1));
        check("ready_low_during_fill", {63'h0, rdy_bad}, 64'h0);
    endtask

    task automatic drain();
        for (int c = 0; c < 60 && exp_q.size() != 0; c++) @(negedge clock);
        check("drain_queue", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [8];
        int   waits, total_waits, acc, pops0, pops_at5;
        logic [8:0]  a, last_wa;
        logic [63:0] d;

        tbl[0] = '{1'b1, 9'h010, 64'h1122334455667788, 8'hFF, 64'h0};
        tbl[1] = '{1'b1, 9'h010, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 64'h0};
        tbl[2] = '{1'b0, 9'h010, 64'h0,                8'h00, 64'h11223344AAAAAAAA};
        tbl[3] = '{1'b1, 9'h1FF, 64'hCAFEBABE12345678, 8'h81, 64'h0};
        tbl[4] = '{1'b0, 9'h1FF, 64'h0,                8'h00, 64'hCA00000000000078};
        tbl[5] = '{1'b0, 9'h000, 64'h0,                8'h00, 64'h0};
        tbl[6] = '{1'b1, 9'h000, 64'hFFFFFFFFFFFFFFFF, 8'h3C, 64'h0};
        tbl[7] = '{1'b0, 9'h000, 64'h0,                8'h00, 64'h0000FFFFFFFF0000};

        for (int i = 0; i < 512; i++) model[i] = 64'h0;
        reset_n        = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_addr   = 9'h0;
        bus.req_data   = 64'h0;
        bus.req_mask   = 8'h0;
        bus.resp_ready = 1'b1;

        // Reset values.
        #2;
        check("rst_req_ready", {63'h0, bus.req_ready}, 64'h0);
        check("rst_resp_valid", {63'h0, bus.resp_valid}, 64'h0);
        check("rst_init_done", {63'h0, init_done}, 64'h0);
        check("rst_W0_en", {63'h0, bus.W0_en}, 64'h0);
        check("rst_R0_en", {63'h0, bus.R0_en}, 64'h0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        check_fill();

        // First read after fill: response exactly two cycles after acceptance.
        @(posedge clock); #1;
        send(1'b0, 9'h1A5, 64'h0, 8'h0, 64'h0, waits);
        @(negedge clock);
        check("lat_t1_resp_valid", {63'h0, bus.resp_valid}, 64'h0);
        @(negedge clock);
        check("lat_t2_resp_valid", {63'h0, bus.resp_valid}, 64'h1);
        @(posedge clock); #1;

        // Table-driven vectors, back to back.
        total_waits = 0;
        for (int i = 0; i < 8; i++) begin
            send(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].m, tbl[i].exp, waits);
            total_waits += waits;
        end
        check("table_back_to_back", 64'(total_waits), 64'd0);
        drain();

        // Backpressure: seed addresses, then offer 6 reads with resp_ready low.
        @(posedge clock); #1;
        for (int k = 0; k < 6; k++) begin
            a = 9'h020 + 9'(k);
            send(1'b1, a, 64'h0101010101010101 * 64'(k + 1), 8'hFF, 64'h0, waits);
        end
        drain();
        @(posedge clock); #1;
        bus.resp_ready = 1'b0;
        acc = 0;
        pops0 = n_pop;
        pops_at5 = -1;
        bus.req_write = 1'b0;
        bus.req_addr  = 9'h020;
        bus.req_valid = 1'b1;
        for (int phase = 0; phase < 2; phase++) begin
            for (int c = 0; c < 14; c++) begin
                @(negedge clock);
                if (bus.req_valid && bus.req_ready) begin
                    exp_q.push_back('{1'b0, model[bus.req_addr]});
                    acc++;
                    if (acc == 5) pops_at5 = n_pop - pops0;
                end
                @(posedge clock); #1;
                if (acc < 6) bus.req_addr = 9'h020 + 9'(acc);
                else bus.req_valid = 1'b0;
            end
            if (phase == 0) begin
                check("bp_accepted_4", 64'(acc), 64'd4);
                check("bp_req_ready_low", {63'h0, bus.req_ready}, 64'h0);
                check("bp_resp_pending", {63'h0, bus.resp_valid}, 64'h1);
                bus.resp_ready = 1'b1;
            end
        end
        check("bp_accepted_6", 64'(acc), 64'd6);
        check("bp_fifth_after_first_resp", {63'h0, pops_at5 >= 1}, 64'h1);
        bus.req_valid = 1'b0;
        drain();

        // Streaming: alternating random writes/reads, one per cycle.
        @(posedge clock); #1;
        total_waits = 0;
        last_wa = 9'h0;
        for (int i = 0; i < 100; i++) begin
            if (i % 2 == 0) begin
                a = 9'($urandom_range(0, 511));
                d = {$urandom, $urandom};
                last_wa = a;
                send(1'b1, a, d, 8'($urandom_range(0, 255)), 64'h0, waits);
            end else begin
                a = ($urandom_range(0, 1) == 1) ? last_wa : 9'($urandom_range(0, 511));
                send(1'b0, a, 64'h0, 8'h0, model[a], waits);
            end
            total_waits += waits;
        end
        check("stream_one_per_cycle", 64'(total_waits), 64'd0);
        drain();

        // Reset with three responses queued.
        @(posedge clock); #1;
        bus.resp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            a = 9'h020 + 9'(k);
            send(1'b0, a, 64'h0, 8'h0, model[a], waits);
        end
        repeat (3) @(negedge clock);
        check("pre_rst_resp_valid", {63'h0, bus.resp_valid}, 64'h1);
        @(posedge clock); #1;
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_resp_valid", {63'h0, bus.resp_valid}, 64'h0);
        check("midrst_req_ready", {63'h0, bus.req_ready}, 64'h0);
        check("midrst_init_done", {63'h0, init_done}, 64'h0);
        check("midrst_W0_en", {63'h0, bus.W0_en}, 64'h0);
        for (int i = 0; i < 512; i++) model[i] = 64'h0;
        bus.resp_ready = 1'b1;
        @(posedge clock); #1;
        reset_n = 1'b1;
        check_fill();
        @(posedge clock); #1;
        send(1'b0, 9'h020, 64'h0, 8'h0, model[9'h020], waits);
        drain();
        repeat (4) @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
